// File: rtl/rpn_tokenizer_if.sv
// Token stream from the tokenizer to the RPN stack engine.
// Latency: n/a (signal bundle only).
// Backpressure: tok_valid/tok_ready; a token moves when both are high on a clock edge.
//
// Signals:
//   tok_valid  tokenizer -> engine  head token present
//   tok_ready  engine -> tokenizer  head token consumed this cycle
//   tok_type   tokenizer -> engine  0 NUM, 1 OP, 2 EVAL
//   tok_num    tokenizer -> engine  literal value (NUM only, else 0)
//   tok_op     tokenizer -> engine  0 '+', 1 '-', 2 '*', 3 '/' (OP only, else 0)
interface rpn_tokenizer_if #(
   parameter int NUM_WIDTH = 16
) ();
   logic                 tok_valid;
   logic                 tok_ready;
   logic [1:0]           tok_type;
   logic [NUM_WIDTH-1:0] tok_num;
   logic [1:0]           tok_op;

   modport master (
      output tok_valid,
      output tok_type,
      output tok_num,
      output tok_op,
      input  tok_ready
   );

   modport slave (
      input  tok_valid,
      input  tok_type,
      input  tok_num,
      input  tok_op,
      output tok_ready
   );
endinterface

// File: rtl/rpn_tokenizer.sv
// Turns received ASCII bytes into NUM/OP/EVAL calculator tokens held in a small FIFO.
// Latency: token pushed on an i_rx_done cycle is at the FIFO head next cycle; errors pulse next cycle.
// Backpressure: none on input; a byte whose tokens do not fit the free space is dropped (OVERRUN).
//
// Ports:
//   i_clk, i_rst_n          clock, asynchronous active-low reset
//   i_rx_done, i_data       received-byte strobe and byte
//   tok                     token stream (rpn_tokenizer_if.master)
//   o_err, o_err_code       1-cycle error pulse; 1 BAD_CHAR, 2 NUM_OVF, 3 OVERRUN
//   o_busy                  a literal is being accumulated
//   o_echo_valid/o_echo_data  only with RPN_TOK_ECHO_EN defined: echo of every accepted byte
module rpn_tokenizer #(
   parameter int NUM_WIDTH  = 16,
   parameter int FIFO_DEPTH = 4
) (
   input  logic        i_clk,
   input  logic        i_rst_n,
   input  logic        i_rx_done,
   input  logic [7:0]  i_data,
   rpn_tokenizer_if.master tok,
   output logic        o_err,
   output logic [1:0]  o_err_code,
   output logic        o_busy
`ifdef RPN_TOK_ECHO_EN
   ,
   output logic        o_echo_valid,
   output logic [7:0]  o_echo_data
`endif
);

   localparam int AW   = $clog2(FIFO_DEPTH);
   localparam int CW   = AW + 1;
   localparam int ACCW = NUM_WIDTH + 4;

   localparam logic [1:0] TOK_NUM  = 2'd0;
   localparam logic [1:0] TOK_OP   = 2'd1;
   localparam logic [1:0] TOK_EVAL = 2'd2;

   localparam logic [1:0] ERR_BAD_CHAR = 2'd1;
   localparam logic [1:0] ERR_NUM_OVF  = 2'd2;
   localparam logic [1:0] ERR_OVERRUN  = 2'd3;

   typedef enum logic {
      ST_IDLE,
      ST_NUM
   } state_t;

   typedef struct packed {
      logic [1:0]           ttype;
      logic [NUM_WIDTH-1:0] num;
      logic [1:0]           op;
   } tok_t;

   state_t               state_reg, state_nxt;
   logic [NUM_WIDTH-1:0] acc_reg, acc_nxt;
   logic                 ovf_reg, ovf_nxt;
   logic                 err_reg, err_nxt;
   logic [1:0]           err_code_reg, err_code_nxt;

   tok_t                 mem [FIFO_DEPTH];
   logic [AW-1:0]        wr_ptr, rd_ptr;
   logic [CW-1:0]        count_reg, free_cnt;

   logic                 push0, push1, pop, accept;
   logic [1:0]           n_push, need;
   tok_t                 tok0, tok1, term_tok, num_tok, head;

   // Byte classification
   logic                 is_digit, is_op, is_eval, is_sep, is_bad, is_term;
   logic [1:0]           op_code;
   logic [ACCW-1:0]      acc_ext, acc_mul;
   logic                 mul_ovf;

   always_comb begin
      is_digit = (i_data >= 8'h30) && (i_data <= 8'h39);
      is_op    = 1'b0;
      op_code  = 2'd0;
      case (i_data)
         8'h2B: begin is_op = 1'b1; op_code = 2'd0; end
         8'h2D: begin is_op = 1'b1; op_code = 2'd1; end
         8'h2A: begin is_op = 1'b1; op_code = 2'd2; end
         8'h2F: begin is_op = 1'b1; op_code = 2'd3; end
         default: ;
      endcase
      is_eval = (i_data == 8'h3D) || (i_data == 8'h0D);
      is_sep  = (i_data == 8'h20) || (i_data == 8'h0A) || (i_data == 8'h09);
      is_bad  = !(is_digit || is_op || is_eval || is_sep);
      is_term = is_op || is_eval;
   end

   // acc*10 + d via shifts; the 4 spare bits catch any result above the literal range
   always_comb begin
      acc_ext = ACCW'(acc_reg);
      acc_mul = (acc_ext << 3) + (acc_ext << 1) + ACCW'(i_data[3:0]);
      mul_ovf = |acc_mul[ACCW-1:NUM_WIDTH];
   end

   always_comb begin
      term_tok       = '0;
      term_tok.ttype = is_op ? TOK_OP : TOK_EVAL;
      term_tok.op    = is_op ? op_code : 2'd0;
      num_tok        = '0;
      num_tok.ttype  = TOK_NUM;
      num_tok.num    = acc_reg;
   end

   // Free space is taken from the registered count only; a pop in the same
   // cycle does not make room for this byte.
   assign free_cnt = CW'(FIFO_DEPTH) - count_reg;

   // Next-state / token generation
   always_comb begin
      state_nxt    = state_reg;
      acc_nxt      = acc_reg;
      ovf_nxt      = ovf_reg;
      err_nxt      = 1'b0;
      err_code_nxt = 2'd0;
      push0        = 1'b0;
      push1        = 1'b0;
      tok0         = '0;
      tok1         = '0;
      accept       = 1'b0;
      need         = 2'd0;

      if (state_reg == ST_NUM && !is_digit) begin
         // An overflowed literal is discarded, so it needs no slot
         need = (ovf_reg ? 2'd0 : 2'd1) + (is_term ? 2'd1 : 2'd0);
      end else if (is_term) begin
         need = 2'd1;
      end

      if (i_rx_done) begin
         if (is_bad) begin
            err_nxt      = 1'b1;
            err_code_nxt = ERR_BAD_CHAR;
         end else if (CW'(need) > free_cnt) begin
            err_nxt      = 1'b1;
            err_code_nxt = ERR_OVERRUN;
         end else begin
            accept = 1'b1;
            case (state_reg)
               ST_IDLE: begin
                  if (is_digit) begin
                     state_nxt = ST_NUM;
                     acc_nxt   = NUM_WIDTH'(i_data[3:0]);
                     ovf_nxt   = 1'b0;
                  end else if (is_term) begin
                     push0 = 1'b1;
                     tok0  = term_tok;
                  end
               end
               ST_NUM: begin
                  if (is_digit) begin
                     // Once overflowed, acc is frozen until the literal ends
                     if (!ovf_reg) begin
                        if (mul_ovf) ovf_nxt = 1'b1;
                        else         acc_nxt = acc_mul[NUM_WIDTH-1:0];
                     end
                  end else begin
                     if (ovf_reg) begin
                        err_nxt      = 1'b1;
                        err_code_nxt = ERR_NUM_OVF;
                        if (is_term) begin
                           push0 = 1'b1;
                           tok0  = term_tok;
                        end
                     end else begin
                        push0 = 1'b1;
                        tok0  = num_tok;
                        if (is_term) begin
                           push1 = 1'b1;
                           tok1  = term_tok;
                        end
                     end
                     state_nxt = ST_IDLE;
                     acc_nxt   = '0;
                     ovf_nxt   = 1'b0;
                  end
               end
               default: state_nxt = ST_IDLE;
            endcase
         end
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_reg    <= ST_IDLE;
         acc_reg      <= '0;
         ovf_reg      <= 1'b0;
         err_reg      <= 1'b0;
         err_code_reg <= 2'd0;
      end else begin
         state_reg    <= state_nxt;
         acc_reg      <= acc_nxt;
         ovf_reg      <= ovf_nxt;
         err_reg      <= err_nxt;
         err_code_reg <= err_code_nxt;
      end
   end

   // Token FIFO: up to two writes per cycle, one read
   assign pop    = tok.tok_ready && (count_reg != '0);
   assign n_push = {1'b0, push0} + {1'b0, push1};

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         count_reg <= '0;
      end else begin
         if (push0) mem[wr_ptr] <= tok0;
         if (push1) mem[wr_ptr + AW'(1)] <= tok1;
         wr_ptr    <= wr_ptr + AW'(n_push);
         if (pop) rd_ptr <= rd_ptr + AW'(1);
         count_reg <= count_reg + CW'(n_push) - CW'(pop);
      end
   end

   // Head fields forced to zero while empty so stale entries never show
   always_comb begin
      head = '0;
      if (count_reg != '0) head = mem[rd_ptr];
   end

   assign tok.tok_valid = (count_reg != '0);
   assign tok.tok_type  = head.ttype;
   assign tok.tok_num   = head.num;
   assign tok.tok_op    = head.op;

   assign o_err      = err_reg;
   assign o_err_code = err_code_reg;
   assign o_busy     = (state_reg == ST_NUM);

`ifdef RPN_TOK_ECHO_EN
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         o_echo_valid <= 1'b0;
         o_echo_data  <= 8'h00;
      end else begin
         o_echo_valid <= accept;
         o_echo_data  <= accept ? i_data : 8'h00;
      end
   end
`endif

endmodule
